// File: rtl/pixel_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_writer: clips plot requests to the screen, queues linearised writes   |
// | in a small FIFO and drains them to a stallable framebuffer port. Rev 1.0    |
// +----------------------------------------------------------------------------+
module pixel_writer #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_x,
  input  logic [6:0]  in_y,
  input  logic [2:0]  in_colour,
  input  logic        in_plot,
  output logic        in_ready,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic        idle,
  output logic        overflow,
  output logic [15:0] clip_count,
  input  logic        clr_status
);

  localparam int                c_ptr_w   = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]  c_full    = (c_ptr_w + 1)'(DEPTH);
  localparam logic [c_ptr_w:0]  c_cnt_one = (c_ptr_w + 1)'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  logic [17:0]        r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               r_overflow;
  logic [15:0]        r_clip_count;

  logic        w_in_range;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_drop;
  logic        w_clip;
  logic [14:0] w_addr;
  logic [17:0] w_head;

  assign w_in_range = ({24'd0, in_x} < 32'(WIDTH)) && ({25'd0, in_y} < 32'(HEIGHT));
  assign w_full     = (r_count == c_full);
  assign w_empty    = (r_count == '0);
  assign w_push     = in_plot && w_in_range && !w_full;
  assign w_drop     = in_plot && w_in_range && w_full;
  assign w_clip     = in_plot && !w_in_range;
  assign w_pop      = !w_empty && fb_ready;
  assign w_addr     = ({8'd0, in_y} * 15'(WIDTH)) + {7'd0, in_x};
  assign w_head     = r_mem[r_rd_ptr];

  // Outputs are forced to zero when empty so reset values appear without a clock.
  assign in_ready   = !w_full;
  assign idle       = w_empty;
  assign fb_we      = !w_empty;
  assign fb_addr    = w_empty ? 15'd0 : w_head[17:3];
  assign fb_data    = w_empty ? 3'd0  : w_head[2:0];
  assign overflow   = r_overflow;
  assign clip_count = r_clip_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_addr, in_colour};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow   <= 1'b0;
      r_clip_count <= '0;
    end else if (clr_status) begin
      r_overflow   <= 1'b0;
      r_clip_count <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_clip && (r_clip_count != 16'hFFFF)) begin
        r_clip_count <= r_clip_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_writer.sv
`default_nettype none
// Self-checking bench for pixel_writer: queue-based reference model, per-cycle
// compare, directed scenarios plus randomized traffic.
module tb_pixel_writer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_x = '0;
  logic [6:0]  in_y = '0;
  logic [2:0]  in_colour = '0;
  logic        in_plot = 1'b0;
  logic        in_ready;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic        fb_ready = 1'b0;
  logic        idle;
  logic        overflow;
  logic [15:0] clip_count;
  logic        clr_status = 1'b0;

  pixel_writer dut (
    .clk(clk), .rst_n(rst_n), .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
    .in_plot(in_plot), .in_ready(in_ready), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_we(fb_we), .fb_ready(fb_ready), .idle(idle), .overflow(overflow),
    .clip_count(clip_count), .clr_status(clr_status)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {address, colour} plus status, at pixel level.
  typedef struct { int addr; int col; } pix_t;
  pix_t m_q[$];
  bit   m_ovf = 0;
  int   m_clip = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ovf  = 0;
      m_clip = 0;
    end else begin
      bit   ok, was_full;
      pix_t p;
      ok       = (int'(in_x) < 160) && (int'(in_y) < 120);
      was_full = (m_q.size() == DEPTH);
      if (m_q.size() > 0 && fb_ready) void'(m_q.pop_front());
      if (in_plot && ok && !was_full) begin
        p.addr = int'(in_y) * 160 + int'(in_x);
        p.col  = int'(in_colour);
        m_q.push_back(p);
      end
      if (clr_status) begin
        m_ovf = 0; m_clip = 0;
      end else begin
        if (in_plot && ok && was_full) m_ovf = 1;
        if (in_plot && !ok && m_clip < 65535) m_clip++;
      end
    end
  end

  // Per-cycle compare and write monitor, sampled mid-cycle.
  int n_writes = 0;
  int last_addr = -1;
  bit fs_mode = 0;
  int fs_next = 0;
  int fs_err = 0;

  always @(negedge clk) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_q.size() < DEPTH});
    chk("idle", {31'd0, idle}, {31'd0, m_q.size() == 0});
    chk("fb_we", {31'd0, fb_we}, {31'd0, m_q.size() != 0});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("clip_count", {16'd0, clip_count}, m_clip);
    if (m_q.size() != 0) begin
      chk("fb_addr", {17'd0, fb_addr}, m_q[0].addr);
      chk("fb_data", {29'd0, fb_data}, m_q[0].col);
    end
    if (rst_n && fb_we && fb_ready) begin
      n_writes++;
      last_addr = int'(fb_addr);
      if (fs_mode) begin
        if (int'(fb_addr) != fs_next) fs_err++;
        fs_next++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int x, input int y, input int c, input bit plot, input bit rdy);
    in_x = 8'(x); in_y = 7'(y); in_colour = 3'(c); in_plot = plot; fb_ready = rdy;
    tick();
  endtask

  task automatic drain(input string name);
    int n;
    in_plot = 1'b0; fb_ready = 1'b1;
    n = 0;
    while (!idle && n < 200) begin
      tick();
      n++;
    end
    chk(name, {31'd0, idle}, 32'd1);
  endtask

  initial begin
    int w0;
    #12 rst_n = 1'b1;
    tick();

    // Single pixel
    send(5, 3, 5, 1, 1);
    chk("single_we", {31'd0, fb_we}, 32'd1);
    chk("single_addr", {17'd0, fb_addr}, 32'd485);
    chk("single_data", {29'd0, fb_data}, 32'd5);
    send(0, 0, 0, 0, 1);
    chk("single_idle", {31'd0, idle}, 32'd1);

    // Clipping
    send(160, 0, 1, 1, 1);
    send(0, 120, 1, 1, 1);
    chk("clip_idle", {31'd0, idle}, 32'd1);
    chk("clip_cnt", {16'd0, clip_count}, 32'd2);
    send(159, 119, 6, 1, 1);
    chk("corner_addr", {17'd0, fb_addr}, 32'd19199);
    drain("corner_drain");

    // Backpressure
    for (int i = 0; i < 8; i++) send(i, 10, i, 1, 0);
    chk("bp_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_head", {17'd0, fb_addr}, 32'd1600);
    send(8, 10, 0, 1, 0);
    chk("bp_ovf", {31'd0, overflow}, 32'd1);
    w0 = n_writes;
    drain("bp_drain");
    chk("bp_writes", n_writes - w0, 32'd8);
    chk("bp_last", last_addr, 32'd1607);

    // Simultaneous push/pop keeps occupancy at 4
    for (int i = 0; i < 4; i++) send(i, 20, 1, 1, 0);
    for (int i = 0; i < 10; i++) send(50 + i, 20, 2, 1, 1);
    in_plot = 1'b0; fb_ready = 1'b0;
    #1;
    w0 = n_writes;
    drain("sim_drain");
    chk("sim_occ", n_writes - w0, 32'd4);
    clr_status = 1'b1;
    send(200, 0, 0, 1, 1);
    clr_status = 1'b0;
    chk("clr_ovf", {31'd0, overflow}, 32'd0);
    chk("clr_clip", {16'd0, clip_count}, 32'd0);

    // Full screen fill
    w0 = n_writes;
    fs_mode = 1;
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) send(x, y, 2, 1, 1);
    drain("fs_drain");
    fs_mode = 0;
    chk("fs_writes", n_writes - w0, 32'd19200);
    chk("fs_order_err", fs_err, 32'd0);
    chk("fs_last", last_addr, 32'd19199);
    chk("fs_ovf", {31'd0, overflow}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      clr_status = ($urandom_range(0, 60) == 0);
      send($urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 7),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    clr_status = 1'b0;

    // Asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) send(i, 30, 3, 1, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_we", {31'd0, fb_we}, 32'd0);
    chk("rst_addr", {17'd0, fb_addr}, 32'd0);
    chk("rst_data", {29'd0, fb_data}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_clip", {16'd0, clip_count}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++)
      send($urandom_range(0, 170), $urandom_range(0, 125), $urandom_range(0, 7),
           $urandom_range(0, 1), $urandom_range(0, 1));
    drain("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
